timer_array: RTL



---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_channel.sv | 93 +++++++++
 rtl/timer_array.sv | 67 ++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer array: register map, CTRL fields, mode codes and FSM states.
package timer_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_FREE    = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2
  } state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT registers, sequencing FSM and sticky PEND.
// state   | meaning
// ST_IDLE | stopped, COUNT holds ; ST_LOAD | COUNT <= PRESET ; ST_CNT | counting down
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl_i,
  input  logic             wr_preset_i,
  input  logic             wr_status_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [3:0]       ctrl_o,
  output logic [WIDTH-1:0] preset_o,
  output logic [WIDTH-1:0] count_o,
  output logic             pend_o
);

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             pend_set, en_clr;
  logic [1:0]       mode;

  assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_set = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      ST_IDLE: if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (mode == MODE_FREE) begin
          count_d = count_q - WIDTH'(1);
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // Terminal count; a PRESET of 0 lands here too, so it acts as 1.
          pend_set = 1'b1;
          if (mode == MODE_RELOAD) begin
            count_d = preset_q;
          end else begin
            count_d = '0;
            en_clr  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ctrl_d = ctrl_q;
    if (en_clr) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl_i) ctrl_d = wdata_i[3:0];

    preset_d = wr_preset_i ? wdata_i : preset_q;
    pend_d   = pend_set | (pend_q & ~(wr_status_i & wdata_i[0]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign preset_o = preset_q;
  assign count_o  = count_q;
  assign pend_o   = pend_q;

endmodule

// File: rtl/timer_array.sv
// Memory-mapped array of NUM_CH down-counting timers with address decode, read mux and IRQ reduction.
module timer_array
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 32,
  parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH_BITS+3:0]   Addr_In,
  input  logic                 WE,
  input  logic [31:0]          Data_In,
  output logic [31:0]          Data_Out,
  output logic                 IRQ,
  output logic [NUM_CH-1:0]    Irq_Vec
);

  logic [CH_BITS-1:0] ch_sel;
  logic [3:0]         off;
  logic [3:0]         ctrl   [NUM_CH];
  logic [WIDTH-1:0]   preset [NUM_CH];
  logic [WIDTH-1:0]   count  [NUM_CH];
  logic [NUM_CH-1:0]  pend;

  assign ch_sel = Addr_In[CH_BITS+3:4];
  assign off    = Addr_In[3:0];

  // Channel indices >= NUM_CH never match a generate index, so they decode to nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = WE && (ch_sel == CH_BITS'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_ctrl_i   (hit && (off == OFF_CTRL)),
      .wr_preset_i (hit && (off == OFF_PRESET)),
      .wr_status_i (hit && (off == OFF_STATUS)),
      .wdata_i     (Data_In[WIDTH-1:0]),
      .ctrl_o      (ctrl[i]),
      .preset_o    (preset[i]),
      .count_o     (count[i]),
      .pend_o      (pend[i])
    );

    assign Irq_Vec[i] = pend[i] & ctrl[i][CTRL_IM];
  end

  assign IRQ = |Irq_Vec;

  always_comb begin
    Data_Out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_BITS'(i)) begin
        case (off)
          OFF_CTRL:   Data_Out = 32'(ctrl[i]);
          OFF_PRESET: Data_Out = 32'(preset[i]);
          OFF_COUNT:  Data_Out = 32'(count[i]);
          OFF_STATUS: Data_Out = 32'(pend[i]);
          default:    Data_Out = '0;
        endcase
      end
    end
  end

endmodule
